// File: rtl/soc_simple_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : soc_simple_mem_arbiter_if
//  Description : Bus bundle for the on-chip memory arbiter. It carries the
//                instruction-fetch port, the data port and the RAM-side port.
//                slave  = arbiter view (accepts CPU requests, drives the RAM)
//                master = environment view (CPU masters plus RAM instance)
//  Revision    : 1.0 - initial release
// ============================================================================
interface soc_simple_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  // Instruction-fetch port (read-only)
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;
  logic              i_readdatavalid;

  // Data port (read/write)
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [BE_W-1:0]   d_byteenable;
  logic [DATA_W-1:0] d_writedata;
  logic              d_waitrequest;
  logic [DATA_W-1:0] d_readdata;
  logic              d_readdatavalid;

  // RAM side
  logic [ADDR_W-1:0] m_address;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  modport slave (
    input  i_address, i_read,
    output i_waitrequest, i_readdata, i_readdatavalid,
    input  d_address, d_read, d_write, d_byteenable, d_writedata,
    output d_waitrequest, d_readdata, d_readdatavalid,
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    input  m_readdata
  );

  modport master (
    output i_address, i_read,
    input  i_waitrequest, i_readdata, i_readdatavalid,
    output d_address, d_read, d_write, d_byteenable, d_writedata,
    input  d_waitrequest, d_readdata, d_readdatavalid,
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    output m_readdata
  );
endinterface
`default_nettype wire

// File: rtl/soc_simple_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : soc_simple_mem_arbiter
//  Description : Round-robin arbiter sharing one single-port 1-cycle-latency
//                RAM between the instruction-fetch and data ports. Grant is
//                combinational; each returning read word is steered to its
//                owner by a one-cycle pending flag per port.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_simple_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  soc_simple_mem_arbiter_if.slave   bus
);

  localparam logic [BE_W-1:0]   c_BE_ALL    = {BE_W{1'b1}};
  localparam logic [BE_W-1:0]   c_BE_NONE   = {BE_W{1'b0}};
  localparam logic [ADDR_W-1:0] c_ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [0:0] {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

  grant_t r_last_grant;
  logic   r_pend_i;
  logic   r_pend_d;

  logic   w_i_req;
  logic   w_d_req;
  logic   w_grant_i;
  logic   w_grant_d;
  logic   w_any_grant;
  logic   w_d_wr;
  logic   w_d_rd_only;

  // Request decode and round-robin grant: on contention the port that did
  // not win last time is served; a lone requester always wins.
  always_comb begin
    w_i_req     = bus.i_read;
    w_d_req     = bus.d_read | bus.d_write;
    w_grant_i   = w_i_req & (~w_d_req | (r_last_grant == GNT_DATA));
    w_grant_d   = w_d_req & ~w_grant_i;
    w_any_grant = w_grant_i | w_grant_d;
    // read+write together behaves as a plain write with no read response
    w_d_wr      = w_grant_d & bus.d_write;
    w_d_rd_only = w_grant_d & bus.d_read & ~bus.d_write;
  end

  assign bus.i_waitrequest = w_i_req & ~w_grant_i;
  assign bus.d_waitrequest = w_d_req & ~w_grant_d;

  // RAM drive; the enables are forced low during reset so an in-flight
  // request cannot corrupt memory while the system is being reset.
  always_comb begin
    bus.m_chipselect = w_any_grant & ~reset;
    bus.m_write      = w_d_wr & ~reset;
    bus.m_writedata  = bus.d_writedata;
    bus.m_clken      = 1'b1;
    bus.m_address    = c_ADDR_ZERO;
    bus.m_byteenable = c_BE_NONE;
    if (w_grant_i) begin
      bus.m_address    = bus.i_address;
      bus.m_byteenable = c_BE_ALL;
    end else if (w_grant_d) begin
      bus.m_address    = bus.d_address;
      bus.m_byteenable = w_d_wr ? bus.d_byteenable : c_BE_ALL;
    end
  end

  // Read data is fanned out to both ports; only the valid qualifies it.
  assign bus.i_readdata      = bus.m_readdata;
  assign bus.d_readdata      = bus.m_readdata;
  assign bus.i_readdatavalid = r_pend_i;
  assign bus.d_readdatavalid = r_pend_d;

  // Grant history and one-cycle read-ownership tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= GNT_DATA;
      r_pend_i     <= 1'b0;
      r_pend_d     <= 1'b0;
    end else begin
      r_pend_i <= w_grant_i;
      r_pend_d <= w_d_rd_only;
      if (w_any_grant) begin
        r_last_grant <= w_grant_d ? GNT_DATA : GNT_INST;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_simple_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_simple_mem_arbiter
//  Description : Self-checking bench for soc_simple_mem_arbiter with a
//                behavioural 1-cycle-latency RAM, a vector table for the
//                combinational grant/RAM drive and a scoreboard for reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_simple_mem_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  soc_simple_mem_arbiter_if #(.ADDR_W(15), .DATA_W(32), .BE_W(4)) bus ();

  soc_simple_mem_arbiter #(.ADDR_W(15), .DATA_W(32), .BE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory image shared by the RAM model and the reference model.
  function automatic logic [31:0] preload(input logic [14:0] a);
    return (a == 15'h7FFF) ? 32'h0 : {16'hC0DE, 1'b0, a};
  endfunction

  // Behavioural RAM: registered address, one cycle of read latency.
  logic [31:0] ram_w [int];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bus.m_chipselect && bus.m_clken) begin
      if (bus.m_write) begin
        logic [31:0] word;
        word = ram_w.exists(int'(bus.m_address)) ? ram_w[int'(bus.m_address)] : preload(bus.m_address);
        for (int b = 0; b < 4; b++)
          if (bus.m_byteenable[b]) word[8*b +: 8] = bus.m_writedata[8*b +: 8];
        ram_w[int'(bus.m_address)] = word;
      end else begin
        ram_q <= ram_w.exists(int'(bus.m_address)) ? ram_w[int'(bus.m_address)] : preload(bus.m_address);
      end
    end
  end
  assign bus.m_readdata = ram_q;

  // Reference memory updated only from the bench's own expectations.
  logic [31:0] ref_w [int];
  function automatic logic [31:0] ref_rd(input logic [14:0] a);
    return ref_w.exists(int'(a)) ? ref_w[int'(a)] : preload(a);
  endfunction
  task automatic ref_write(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] word;
    word = ref_rd(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) word[8*b +: 8] = d[8*b +: 8];
    ref_w[int'(a)] = word;
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t q_i[$];
  exp_t q_d[$];

  typedef struct {
    logic        pre_rst;
    logic        ir;
    logic [14:0] ia;
    logic        dr;
    logic        dw;
    logic [3:0]  be;
    logic [14:0] da;
    logic [31:0] wd;
    logic        e_iw;
    logic        e_dw;
    logic        e_cs;
    logic        e_wr;
    logic [14:0] e_ma;
    logic [3:0]  e_be;
  } vec_t;
  vec_t vecs [19];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [14:0] ia, input logic dr, input logic dw,
                       input logic [3:0] be, input logic [14:0] da, input logic [31:0] wd);
    bus.i_read = ir; bus.i_address = ia;
    bus.d_read = dr; bus.d_write = dw; bus.d_byteenable = be;
    bus.d_address = da; bus.d_writedata = wd;
  endtask

  // Response side: each valid must match the scoreboard head due this cycle.
  task automatic monitor();
    cmp("valid_exclusive", {31'h0, bus.i_readdatavalid & bus.d_readdatavalid}, 32'h0);
    if (q_i.size() > 0 && q_i[0].due == cyc) begin
      cmp("i_readdatavalid", {31'h0, bus.i_readdatavalid}, 32'h1);
      cmp("i_readdata", bus.i_readdata, q_i[0].data);
      void'(q_i.pop_front());
    end else begin
      cmp("i_readdatavalid_idle", {31'h0, bus.i_readdatavalid}, 32'h0);
    end
    if (q_d.size() > 0 && q_d[0].due == cyc) begin
      cmp("d_readdatavalid", {31'h0, bus.d_readdatavalid}, 32'h1);
      cmp("d_readdata", bus.d_readdata, q_d[0].data);
      void'(q_d.pop_front());
    end else begin
      cmp("d_readdatavalid_idle", {31'h0, bus.d_readdatavalid}, 32'h0);
    end
  endtask

  // Finish the current cycle: check responses mid-cycle, then step to 1ns
  // after the next rising edge where inputs are driven.
  task automatic cycle_end();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_ram_side(input logic e_iw, input logic e_dw, input logic e_cs,
                                input logic e_wr, input logic [14:0] e_ma, input logic [3:0] e_be);
    cmp("i_waitrequest", {31'h0, bus.i_waitrequest}, {31'h0, e_iw});
    cmp("d_waitrequest", {31'h0, bus.d_waitrequest}, {31'h0, e_dw});
    cmp("m_chipselect", {31'h0, bus.m_chipselect}, {31'h0, e_cs});
    cmp("m_write", {31'h0, bus.m_write}, {31'h0, e_wr});
    cmp("m_address", {17'h0, bus.m_address}, {17'h0, e_ma});
    cmp("m_byteenable", {28'h0, bus.m_byteenable}, {28'h0, e_be});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    #2;
    cmp("rst_i_valid", {31'h0, bus.i_readdatavalid}, 32'h0);
    cmp("rst_d_valid", {31'h0, bus.d_readdatavalid}, 32'h0);
    cmp("rst_chipselect", {31'h0, bus.m_chipselect}, 32'h0);
    cmp("rst_clken", {31'h0, bus.m_clken}, 32'h1);
    cycle_end();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    ram_q  = 32'h0;
    reset  = 1'b0;
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);

    //             rst  ir   ia        dr   dw   be     da        wd             iw   dw   cs   wr   ma        be
    vecs[0]  = '{1'b0,1'b0,15'h0000,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b0,1'b0,15'h0000,4'h0};
    vecs[1]  = '{1'b0,1'b1,15'h0000,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b1,1'b0,15'h0000,4'hF};
    vecs[2]  = '{1'b0,1'b1,15'h0001,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b1,1'b0,15'h0001,4'hF};
    vecs[3]  = '{1'b0,1'b1,15'h0002,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b1,1'b0,15'h0002,4'hF};
    vecs[4]  = '{1'b0,1'b1,15'h0003,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b1,1'b0,15'h0003,4'hF};
    vecs[5]  = '{1'b0,1'b0,15'h0000,1'b0,1'b1,4'h5,15'h7FFF,32'hDEADBEEF,1'b0,1'b0,1'b1,1'b1,15'h7FFF,4'h5};
    vecs[6]  = '{1'b0,1'b1,15'h7FFF,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b1,1'b0,15'h7FFF,4'hF};
    vecs[7]  = '{1'b0,1'b0,15'h0000,1'b1,1'b1,4'h3,15'h0100,32'h12345678,1'b0,1'b0,1'b1,1'b1,15'h0100,4'h3};
    vecs[8]  = '{1'b0,1'b0,15'h0000,1'b1,1'b0,4'h0,15'h0100,32'h00000000,1'b0,1'b0,1'b1,1'b0,15'h0100,4'hF};
    vecs[9]  = '{1'b0,1'b0,15'h0000,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b0,1'b0,15'h0000,4'h0};
    vecs[10] = '{1'b1,1'b1,15'h0010,1'b1,1'b0,4'h0,15'h0020,32'h00000000,1'b0,1'b1,1'b1,1'b0,15'h0010,4'hF};
    vecs[11] = '{1'b0,1'b1,15'h0010,1'b1,1'b0,4'h0,15'h0020,32'h00000000,1'b1,1'b0,1'b1,1'b0,15'h0020,4'hF};
    vecs[12] = '{1'b0,1'b1,15'h0010,1'b1,1'b0,4'h0,15'h0020,32'h00000000,1'b0,1'b1,1'b1,1'b0,15'h0010,4'hF};
    vecs[13] = '{1'b0,1'b1,15'h0010,1'b1,1'b0,4'h0,15'h0020,32'h00000000,1'b1,1'b0,1'b1,1'b0,15'h0020,4'hF};
    vecs[14] = '{1'b0,1'b0,15'h0000,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b0,1'b0,15'h0000,4'h0};
    vecs[15] = '{1'b0,1'b1,15'h0005,1'b0,1'b1,4'hF,15'h0005,32'hA5A5A5A5,1'b0,1'b1,1'b1,1'b0,15'h0005,4'hF};
    vecs[16] = '{1'b0,1'b1,15'h0005,1'b0,1'b1,4'hF,15'h0005,32'hA5A5A5A5,1'b1,1'b0,1'b1,1'b1,15'h0005,4'hF};
    vecs[17] = '{1'b0,1'b1,15'h0005,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b1,1'b0,15'h0005,4'hF};
    vecs[18] = '{1'b0,1'b0,15'h0000,1'b0,1'b0,4'h0,15'h0000,32'h00000000,1'b0,1'b0,1'b0,1'b0,15'h0000,4'h0};

    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Table-driven section: grant, RAM drive and scoreboard pushes.
    for (int k = 0; k < 19; k++) begin
      if (vecs[k].pre_rst) do_reset();
      drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw, vecs[k].be, vecs[k].da, vecs[k].wd);
      #2;
      check_ram_side(vecs[k].e_iw, vecs[k].e_dw, vecs[k].e_cs, vecs[k].e_wr, vecs[k].e_ma, vecs[k].e_be);
      if (vecs[k].ir && !vecs[k].e_iw)
        q_i.push_back('{cyc + 1, ref_rd(vecs[k].ia)});
      if ((vecs[k].dr || vecs[k].dw) && !vecs[k].e_dw) begin
        if (vecs[k].dw) ref_write(vecs[k].da, vecs[k].be, vecs[k].wd);
        else            q_d.push_back('{cyc + 1, ref_rd(vecs[k].da)});
      end
      cycle_end();
    end
    cmp("merged_word_7fff", ref_rd(15'h7FFF), 32'h00AD00EF);

    // Reset arrives the cycle after an accepted d read: the response is lost.
    drive(1'b0, 15'h0, 1'b1, 1'b0, 4'h0, 15'h0002, 32'h0);
    #2;
    cmp("pre_rst_d_wait", {31'h0, bus.d_waitrequest}, 32'h0);
    cycle_end();
    reset = 1'b1;
    drive(1'b1, 15'h0003, 1'b0, 1'b1, 4'hF, 15'h0040, 32'hFFFFFFFF);
    #2;
    cmp("rst_mid_d_valid", {31'h0, bus.d_readdatavalid}, 32'h0);
    cmp("rst_mid_i_valid", {31'h0, bus.i_readdatavalid}, 32'h0);
    cmp("rst_mid_chipselect", {31'h0, bus.m_chipselect}, 32'h0);
    cmp("rst_mid_write", {31'h0, bus.m_write}, 32'h0);
    cmp("rst_mid_i_wait", {31'h0, bus.i_waitrequest}, 32'h0);
    cmp("rst_mid_d_wait", {31'h0, bus.d_waitrequest}, 32'h1);
    cycle_end();
    #1;
    reset = 1'b0;
    drive(1'b1, 15'h0004, 1'b1, 1'b0, 4'h0, 15'h0006, 32'h0);
    #1;
    cmp("post_rst_i_wait", {31'h0, bus.i_waitrequest}, 32'h0);
    cmp("post_rst_d_wait", {31'h0, bus.d_waitrequest}, 32'h1);
    cmp("post_rst_m_addr", {17'h0, bus.m_address}, 32'h4);
    q_i.push_back('{cyc + 1, ref_rd(15'h0004)});
    cycle_end();
    drive(1'b0, 15'h0, 1'b1, 1'b0, 4'h0, 15'h0006, 32'h0);
    #2;
    cmp("held_d_wait", {31'h0, bus.d_waitrequest}, 32'h0);
    q_d.push_back('{cyc + 1, ref_rd(15'h0006)});
    cycle_end();
    // The write presented during reset must not have reached memory.
    drive(1'b0, 15'h0, 1'b1, 1'b0, 4'h0, 15'h0040, 32'h0);
    #2;
    cmp("chk40_d_wait", {31'h0, bus.d_waitrequest}, 32'h0);
    q_d.push_back('{cyc + 1, 32'hC0DE0040});
    cycle_end();
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    #2;
    check_ram_side(1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0);
    cycle_end();
    cycle_end();

    cmp("q_i_drained", q_i.size(), 32'h0);
    cmp("q_d_drained", q_d.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
